id_ex_pipe_reg: RTL and testbench

ID/EX pipeline register sitting between the decode-stage control/register-file outputs and the EX stage (ALU control, ALU, forwarding unit).
- Captures decoded control fields and operand data once per cycle.
- Freezes on data-cache stall.
- Inserts bubbles on branch flush or invalid decode.
- Defers a flush that arrives during a stall.
- Counts inserted bubbles for performance monitoring.

---
 rtl/id_ex_pipe_reg_if.sv | 61 ++++++
 rtl/id_ex_pipe_reg.sv | 108 ++++++++++
 tb/tb_id_ex_pipe_reg.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_pipe_reg_if.sv
// ID/EX boundary bundle: decode-side fields (_i) in, execute-side registered fields (_o) out.
// valid_i qualifies the ID payload each cycle; stall_i freezes the register; there is no ready back-pressure.
interface id_ex_pipe_reg_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic              stall_i;
    logic              flush_i;
    logic              valid_i;
    logic [2:0]        ALUOp_i;
    logic              RegWrite_i;
    logic              MemtoReg_i;
    logic              MemRead_i;
    logic              MemWrite_i;
    logic              ALUSrc_i;
    logic [DATA_W-1:0] pc_i;
    logic [DATA_W-1:0] RS1data_i;
    logic [DATA_W-1:0] RS2data_i;
    logic [DATA_W-1:0] imm_i;
    logic [9:0]        funct_i;
    logic [REG_AW-1:0] RS1addr_i;
    logic [REG_AW-1:0] RS2addr_i;
    logic [REG_AW-1:0] RDaddr_i;

    logic [2:0]        ALUOp_o;
    logic              RegWrite_o;
    logic              MemtoReg_o;
    logic              MemRead_o;
    logic              MemWrite_o;
    logic              ALUSrc_o;
    logic [DATA_W-1:0] pc_o;
    logic [DATA_W-1:0] RS1data_o;
    logic [DATA_W-1:0] RS2data_o;
    logic [DATA_W-1:0] imm_o;
    logic [9:0]        funct_o;
    logic [REG_AW-1:0] RS1addr_o;
    logic [REG_AW-1:0] RS2addr_o;
    logic [REG_AW-1:0] RDaddr_o;
    logic              valid_o;
    logic              flush_pend_o;
    logic [CNT_W-1:0]  bubble_cnt_o;

    modport master (
        output stall_i, flush_i, valid_i, ALUOp_i, RegWrite_i, MemtoReg_i, MemRead_i,
               MemWrite_i, ALUSrc_i, pc_i, RS1data_i, RS2data_i, imm_i, funct_i,
               RS1addr_i, RS2addr_i, RDaddr_i,
        input  ALUOp_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o,
               pc_o, RS1data_o, RS2data_o, imm_o, funct_o, RS1addr_o, RS2addr_o,
               RDaddr_o, valid_o, flush_pend_o, bubble_cnt_o
    );

    modport slave (
        input  stall_i, flush_i, valid_i, ALUOp_i, RegWrite_i, MemtoReg_i, MemRead_i,
               MemWrite_i, ALUSrc_i, pc_i, RS1data_i, RS2data_i, imm_i, funct_i,
               RS1addr_i, RS2addr_i, RDaddr_i,
        output ALUOp_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o,
               pc_o, RS1data_o, RS2data_o, imm_o, funct_o, RS1addr_o, RS2addr_o,
               RDaddr_o, valid_o, flush_pend_o, bubble_cnt_o
    );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: freezes on stall, inserts bubbles on flush or invalid decode,
// defers a flush seen during a stall, and keeps a saturating bubble count.
module id_ex_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input logic              clk_i,
    input logic              rst_i,
    id_ex_pipe_reg_if.slave  bus
);
    typedef struct packed {
        logic [2:0]        alu_op;
        logic              reg_write;
        logic              mem_to_reg;
        logic              mem_read;
        logic              mem_write;
        logic              alu_src;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] rs1_data;
        logic [DATA_W-1:0] rs2_data;
        logic [DATA_W-1:0] imm;
        logic [9:0]        funct;
        logic [REG_AW-1:0] rs1_addr;
        logic [REG_AW-1:0] rs2_addr;
        logic [REG_AW-1:0] rd_addr;
        logic              valid;
    } stage_t;

    stage_t           stage_q, stage_d, bubble_c, load_c;
    logic             flush_pend_q, flush_pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A bubble doubles as the reset image: ALUOp at the Control default, everything else zero.
    always_comb begin
        bubble_c        = '0;
        bubble_c.alu_op = 3'b111;
    end

    always_comb begin
        load_c            = '0;
        load_c.alu_op     = bus.ALUOp_i;
        load_c.reg_write  = bus.RegWrite_i;
        load_c.mem_to_reg = bus.MemtoReg_i;
        load_c.mem_read   = bus.MemRead_i;
        load_c.mem_write  = bus.MemWrite_i;
        load_c.alu_src    = bus.ALUSrc_i;
        load_c.pc         = bus.pc_i;
        load_c.rs1_data   = bus.RS1data_i;
        load_c.rs2_data   = bus.RS2data_i;
        load_c.imm        = bus.imm_i;
        load_c.funct      = bus.funct_i;
        load_c.rs1_addr   = bus.RS1addr_i;
        load_c.rs2_addr   = bus.RS2addr_i;
        load_c.rd_addr    = bus.RDaddr_i;
        load_c.valid      = 1'b1;
    end

    always_comb begin
        stage_d      = stage_q;
        flush_pend_d = flush_pend_q;
        cnt_d        = cnt_q;
        if (bus.stall_i) begin
            if (bus.flush_i) begin
                flush_pend_d = 1'b1;
            end
        end else if (bus.flush_i || flush_pend_q || !bus.valid_i) begin
            // Live and deferred flush merge here into a single bubble.
            stage_d      = bubble_c;
            flush_pend_d = 1'b0;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            stage_d = load_c;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stage_q      <= bubble_c;
            flush_pend_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            stage_q      <= stage_d;
            flush_pend_q <= flush_pend_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.ALUOp_o      = stage_q.alu_op;
    assign bus.RegWrite_o   = stage_q.reg_write;
    assign bus.MemtoReg_o   = stage_q.mem_to_reg;
    assign bus.MemRead_o    = stage_q.mem_read;
    assign bus.MemWrite_o   = stage_q.mem_write;
    assign bus.ALUSrc_o     = stage_q.alu_src;
    assign bus.pc_o         = stage_q.pc;
    assign bus.RS1data_o    = stage_q.rs1_data;
    assign bus.RS2data_o    = stage_q.rs2_data;
    assign bus.imm_o        = stage_q.imm;
    assign bus.funct_o      = stage_q.funct;
    assign bus.RS1addr_o    = stage_q.rs1_addr;
    assign bus.RS2addr_o    = stage_q.rs2_addr;
    assign bus.RDaddr_o     = stage_q.rd_addr;
    assign bus.valid_o      = stage_q.valid;
    assign bus.flush_pend_o = flush_pend_q;
    assign bus.bubble_cnt_o = cnt_q;
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: directed scenarios then random traffic, checked against an
// edge-by-edge reference of the register's rules.
module tb_id_ex_pipe_reg;
    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 4;
    localparam int PW     = 3 + 5 + 4 * DATA_W + 10 + 3 * REG_AW;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    id_ex_pipe_reg_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

    id_ex_pipe_reg #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_pass   = 0;
    string phase    = "reset";

    logic [PW-1:0] m_payload;
    logic          m_valid;
    logic          m_pend;
    int            m_cnt;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s.%s: got %0h expected %0h", phase, tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] bubble_vec();
        logic [PW-1:0] v;
        v = '0;
        v[PW-1 -: 3] = 3'b111;
        return v;
    endfunction

    function automatic logic [PW-1:0] in_vec();
        return {bus.ALUOp_i, bus.RegWrite_i, bus.MemtoReg_i, bus.MemRead_i, bus.MemWrite_i,
                bus.ALUSrc_i, bus.pc_i, bus.RS1data_i, bus.RS2data_i, bus.imm_i, bus.funct_i,
                bus.RS1addr_i, bus.RS2addr_i, bus.RDaddr_i};
    endfunction

    function automatic logic [PW-1:0] out_vec();
        return {bus.ALUOp_o, bus.RegWrite_o, bus.MemtoReg_o, bus.MemRead_o, bus.MemWrite_o,
                bus.ALUSrc_o, bus.pc_o, bus.RS1data_o, bus.RS2data_o, bus.imm_o, bus.funct_o,
                bus.RS1addr_o, bus.RS2addr_o, bus.RDaddr_o};
    endfunction

    // Reference: what EX should hold after this edge, given the inputs present at it.
    task automatic model_edge();
        if (rst) begin
            m_payload = bubble_vec();
            m_valid   = 1'b0;
            m_pend    = 1'b0;
            m_cnt     = 0;
        end else if (bus.stall_i) begin
            m_pend = m_pend | bus.flush_i;
        end else if (bus.flush_i || m_pend || !bus.valid_i) begin
            m_payload = bubble_vec();
            m_valid   = 1'b0;
            m_pend    = 1'b0;
            m_cnt     = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
        end else begin
            m_payload = in_vec();
            m_valid   = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("payload", 256'(out_vec()), 256'(m_payload));
        check("valid", 256'(bus.valid_o), 256'(m_valid));
        check("flush_pend", 256'(bus.flush_pend_o), 256'(m_pend));
        check("bubble_cnt", 256'(bus.bubble_cnt_o), 256'(m_cnt));
    endtask

    task automatic rand_payload();
        bus.ALUOp_i    = 3'($urandom_range(0, 7));
        bus.RegWrite_i = 1'($urandom_range(0, 1));
        bus.MemtoReg_i = 1'($urandom_range(0, 1));
        bus.MemRead_i  = 1'($urandom_range(0, 1));
        bus.MemWrite_i = 1'($urandom_range(0, 1));
        bus.ALUSrc_i   = 1'($urandom_range(0, 1));
        bus.pc_i       = $urandom;
        bus.RS1data_i  = $urandom;
        bus.RS2data_i  = $urandom;
        bus.imm_i      = $urandom;
        bus.funct_i    = 10'($urandom_range(0, 1023));
        bus.RS1addr_i  = 5'($urandom_range(0, 31));
        bus.RS2addr_i  = 5'($urandom_range(0, 31));
        bus.RDaddr_i   = 5'($urandom_range(0, 31));
    endtask

    task automatic set_lw();
        rand_payload();
        bus.ALUOp_i    = 3'b010;
        bus.RegWrite_i = 1'b1;
        bus.MemtoReg_i = 1'b1;
        bus.MemRead_i  = 1'b1;
        bus.MemWrite_i = 1'b0;
        bus.ALUSrc_i   = 1'b1;
        bus.RDaddr_i   = 5'd7;
        bus.imm_i      = 32'h10;
        bus.funct_i    = 10'b0000000_010;
    endtask

    task automatic set_sw();
        rand_payload();
        bus.ALUOp_i    = 3'b000;
        bus.RegWrite_i = 1'b0;
        bus.MemtoReg_i = 1'b0;
        bus.MemRead_i  = 1'b0;
        bus.MemWrite_i = 1'b1;
        bus.ALUSrc_i   = 1'b1;
        bus.RDaddr_i   = 5'd0;
        bus.imm_i      = 32'h24;
        bus.funct_i    = 10'b0000000_010;
    endtask

    initial begin
        bus.stall_i = 1'b0;
        bus.flush_i = 1'b0;
        bus.valid_i = 1'b1;
        rand_payload();

        rst = 1'b1;
        tick();
        rand_payload();
        bus.stall_i = 1'b1;
        bus.flush_i = 1'b1;
        tick();
        rst = 1'b0;
        bus.stall_i = 1'b0;
        bus.flush_i = 1'b0;

        phase = "lw_load";
        set_lw();
        bus.valid_i = 1'b1;
        tick();

        phase = "stall_hold";
        set_sw();
        bus.stall_i = 1'b1;
        repeat (5) tick();
        bus.stall_i = 1'b0;
        phase = "sw_release";
        tick();

        phase = "deferred_flush";
        bus.stall_i = 1'b1;
        rand_payload();
        tick();
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        tick();
        tick();
        bus.stall_i = 1'b0;
        tick();
        set_lw();
        tick();

        phase = "double_flush";
        bus.stall_i = 1'b1;
        bus.flush_i = 1'b1;
        tick();
        bus.stall_i = 1'b0;
        tick();
        bus.flush_i = 1'b0;
        tick();

        phase = "noop";
        rand_payload();
        bus.valid_i    = 1'b0;
        bus.RegWrite_i = 1'b1;
        bus.MemWrite_i = 1'b1;
        tick();

        phase = "saturate";
        for (int i = 0; i < 20; i++) begin
            rand_payload();
            tick();
        end

        phase = "reset_mid_stall";
        bus.stall_i = 1'b1;
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.stall_i = 1'b0;
        bus.valid_i = 1'b1;
        set_lw();
        tick();
        tick();

        phase = "random";
        for (int i = 0; i < 600; i++) begin
            rand_payload();
            bus.stall_i = ($urandom_range(0, 3) == 0);
            bus.flush_i = ($urandom_range(0, 7) == 0);
            bus.valid_i = ($urandom_range(0, 4) != 0);
            rst         = ($urandom_range(0, 149) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
